// File: rtl/controller_pio_pkg.sv
// Shared definitions for the controller PIO blocks: register word offsets,
// edge-type encodings and the per-line edge qualifier.
package controller_pio_pkg;

  // Register word offsets on the Avalon-MM slave
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // arm_cnt value at which edge detection is enabled
  localparam logic [1:0] ARM_DONE = 2'd2;

  // Qualify one line's transition against the configured edge type.
  function automatic logic edge_bit(input logic cur, input logic prev, input int edge_type);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_FALL: edge_bit = fall;
      EDGE_ANY:  edge_bit = rise | fall;
      default:   edge_bit = rise;
    endcase
  endfunction

endpackage

// File: rtl/controller_sense_debounce.sv
// Single-bit debounce filter: the output follows the input only after the
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module controller_sense_debounce
  #(parameter int DEBOUNCE_CYCLES = 50000)
  (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_i,
    output logic filt_o
  );

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Count mismatching cycles; commit the new level on the last one
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sample_i != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sample_i;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/controller_sense_pio.sv
// Avalon-MM input PIO: synchronised external lines, edge capture with
// write-1-to-clear, IRQ mask and a level interrupt.
// Optional build macro CONTROLLER_SENSE_DEBOUNCE_EN inserts a per-bit
// debounce filter between the synchroniser and the sampled level.
module controller_sense_pio
  import controller_pio_pkg::*;
  #(
    parameter int WIDTH           = 12,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
  )
  (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
  );

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("controller_sense_pio: WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("controller_sense_pio: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] sync_q1_q, sync_q2_q;
  logic [WIDTH-1:0] d_cur;
  logic [WIDTH-1:0] d_early;
  logic [WIDTH-1:0] d_prev_q, d_prev_d;
  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchroniser on the asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1_q <= '0;
      sync_q2_q <= '0;
    end else begin
      sync_q1_q <= in_port;
      sync_q2_q <= sync_q1_q;
    end
  end

`ifdef CONTROLLER_SENSE_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    controller_sense_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .sample_i (sync_q2_q[i]),
      .filt_o   (d_cur[i])
    );
  end
  // Filter outputs hold at reset for far longer than the arm window.
  assign d_early = d_cur;
`else
  assign d_cur   = sync_q2_q;
  // Value d_cur takes on the next edge; lets d_prev catch up during arming.
  assign d_early = sync_q1_q;
`endif

  // While arming, d_prev tracks the level d_cur is about to take, so a line
  // already high at reset release shows no transition once detection opens.
  always_comb begin
    arm_cnt_d = (arm_cnt_q == ARM_DONE) ? arm_cnt_q : arm_cnt_q + 2'd1;
    d_prev_d  = (arm_cnt_q == ARM_DONE) ? d_cur : d_early;
  end

  // Arm counter and previous-level register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= '0;
      d_prev_q  <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      d_prev_q  <= d_prev_d;
    end
  end

  // Edge vector, suppressed until arming completes
  always_comb begin
    edge_vec = '0;
    if (arm_cnt_q == ARM_DONE) begin
      for (int i = 0; i < WIDTH; i++) begin
        edge_vec[i] = edge_bit(d_cur[i], d_prev_q[i], EDGE_TYPE);
      end
    end
  end

  // Register updates: W1C on edge capture with set priority, mask load
  always_comb begin
    edge_cap_d = edge_cap_q;
    irqmask_d  = irqmask_q;
    if (wr_en && address == PIO_ADDR_EDGECAP) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end
    if (wr_en && address == PIO_ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    edge_cap_d = edge_cap_d | edge_vec;
  end

  // Read mux; sees current register values, so a same-cycle write reads old data
  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = d_cur;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:          readdata_d = '0;
    endcase
  end

  // Software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap_q <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      edge_cap_q <= edge_cap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  if (WIDTH < 32) begin : g_wdata_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irqmask_q);

endmodule

// File: tb/tb_controller_sense_pio.sv
// Directed bench for controller_sense_pio (WIDTH=12, rising-edge capture).
module tb_controller_sense_pio;
  import controller_pio_pkg::*;

`ifdef CONTROLLER_SENSE_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 50000;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [11:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] v;

  controller_sense_pio #(.WIDTH(12), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0;
`ifndef CONTROLLER_SENSE_DEBOUNCE_EN
    in_port = 12'hFFF;
    wait_cyc(3);
    chk_val("rst_readdata", readdata, 32'h0);
    chk_val("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    wait_cyc(10);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("pwrup_edgecap", v, 32'h0);
    chk_val("pwrup_irq", {31'b0, irq}, 32'h0);
    bus_rd(PIO_ADDR_DATA, v);    chk_val("pwrup_data", v, 32'h0000_0FFF);
    bus_rd(PIO_ADDR_IRQMASK, v); chk_val("pwrup_mask", v, 32'h0);

    // Falling edges are ignored in rising mode
    in_port = 12'h000;
    wait_cyc(4);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("fall_ignored", v, 32'h0);

    // Rising edge on bit0 with exact latency
    bus_wr(PIO_ADDR_IRQMASK, 32'h001);
    in_port[0] = 1'b1;
    @(negedge clk); chk_val("lat_n_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); chk_val("lat_n1_irq", {31'b0, irq}, 32'h0);
    @(negedge clk); chk_val("lat_n2_irq", {31'b0, irq}, 32'h1);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("rise_edgecap", v, 32'h001);
    @(negedge clk);
    address = PIO_ADDR_EDGECAP; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    chk_val("w1c_irq", {31'b0, irq}, 32'h0);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("w1c_edgecap", v, 32'h0);

    // Set/clear race on bit0: set wins
    in_port[0] = 1'b0;
    wait_cyc(4);
    in_port[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    address = PIO_ADDR_EDGECAP; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    chk_val("race_irq", {31'b0, irq}, 32'h1);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("race_edgecap", v, 32'h001);

    // Mask behaviour
    bus_wr(PIO_ADDR_IRQMASK, 32'h0);
    chk_val("mask0_irq", {31'b0, irq}, 32'h0);
    bus_wr(PIO_ADDR_IRQMASK, 32'h800);
    in_port[11] = 1'b1;
    wait_cyc(3);
    chk_val("bit11_irq", {31'b0, irq}, 32'h1);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("bit11_edgecap", v, 32'h801);
    bus_wr(PIO_ADDR_EDGECAP, 32'hFFF);
    chk_val("clrall_irq", {31'b0, irq}, 32'h0);
    in_port[5] = 1'b1;
    wait_cyc(3);
    chk_val("bit5_irq", {31'b0, irq}, 32'h0);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("bit5_edgecap", v, 32'h020);
    in_port[11] = 1'b0;
    wait_cyc(3);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("bit11_fall", v, 32'h020);

    // Reserved and data writes ignored, reserved reads zero
    bus_wr(PIO_ADDR_DATA, 32'hFFF);
    bus_wr(PIO_ADDR_RSVD, 32'hFFF);
    bus_rd(PIO_ADDR_RSVD, v);    chk_val("rsvd_read", v, 32'h0);
    bus_rd(PIO_ADDR_DATA, v);    chk_val("data_read", v, 32'h021);
    bus_rd(PIO_ADDR_IRQMASK, v); chk_val("mask_kept", v, 32'h800);

    // Same-cycle write and read returns the old value
    @(negedge clk);
    address = PIO_ADDR_IRQMASK; writedata = 32'h0F0; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    chk_val("rdwr_old", readdata, 32'h800);
    @(negedge clk);
    chk_val("rdwr_new", readdata, 32'h0F0);

    // Reset mid-operation
    bus_wr(PIO_ADDR_IRQMASK, 32'h080);
    in_port[7] = 1'b1;
    wait_cyc(3);
    chk_val("pre_rst_irq", {31'b0, irq}, 32'h1);
    in_port[2] = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_val("midrst_irq", {31'b0, irq}, 32'h0);
    chk_val("midrst_readdata", readdata, 32'h0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(10);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("rearm_edgecap", v, 32'h0);
    bus_rd(PIO_ADDR_IRQMASK, v); chk_val("rearm_mask", v, 32'h0);
    chk_val("rearm_irq", {31'b0, irq}, 32'h0);
    bus_rd(PIO_ADDR_DATA, v);    chk_val("rearm_data", v, 32'h0A5);
    bus_wr(PIO_ADDR_IRQMASK, 32'h002);
    in_port[1] = 1'b1;
    wait_cyc(3);
    chk_val("post_rst_irq", {31'b0, irq}, 32'h1);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("post_rst_edgecap", v, 32'h002);
`else
    in_port = 12'h000;
    wait_cyc(3);
    chk_val("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    wait_cyc(20);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("db_idle_edgecap", v, 32'h0);
    bus_wr(PIO_ADDR_IRQMASK, 32'h008);

    // 5-cycle glitch must be filtered
    @(negedge clk); in_port[3] = 1'b1;
    wait_cyc(5);
    in_port[3] = 1'b0;
    wait_cyc(30);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("db_short_edgecap", v, 32'h0);
    chk_val("db_short_irq", {31'b0, irq}, 32'h0);

    // 20-cycle pulse gives one rising capture
    @(negedge clk); in_port[3] = 1'b1;
    wait_cyc(20);
    bus_rd(PIO_ADDR_DATA, v);    chk_val("db_long_data", v, 32'h008);
    in_port[3] = 1'b0;
    wait_cyc(30);
    bus_rd(PIO_ADDR_EDGECAP, v); chk_val("db_long_edgecap", v, 32'h008);
    chk_val("db_long_irq", {31'b0, irq}, 32'h1);
    bus_rd(PIO_ADDR_DATA, v);    chk_val("db_after_data", v, 32'h0);
    bus_wr(PIO_ADDR_EDGECAP, 32'h008);
    chk_val("db_w1c_irq", {31'b0, irq}, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
